// File: rtl/register_dump.sv
`default_nettype none
// ============================================================================
// Module  : register_dump
// Brief   : Walks every word of a register file in ascending address order
//           and streams each word out least-significant byte first over a
//           valid/ready byte channel. Pulses o_done when the last byte of the
//           last word has been accepted.
// Revision: 1.0 - initial release
// ============================================================================
module register_dump #(
  parameter int NB_REGISTER = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_BYTE     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic [NB_ADDR-1:0]     o_r_addr,
  input  logic [NB_REGISTER-1:0] i_r_data,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int BYTES_PER_WORD = NB_REGISTER / NB_BYTE;
  localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [NB_ADDR-1:0]     addr_cnt;
  logic [NB_ADDR-1:0]     addr_next;
  logic [NB_REGISTER-1:0] shift_reg;
  logic [NB_REGISTER-1:0] shift_next;
  logic [NB_BCNT-1:0]     byte_cnt;
  logic [NB_BCNT-1:0]     byte_next;
  logic                   transfer;

  // A byte moves only while SEND is offering it and the transmitter accepts.
  assign transfer = (state == SEND) && i_tx_ready;

  // Outputs are pure decodes of the registered state, so they never glitch
  // with i_tx_ready and naturally hold steady across stalled cycles.
  assign o_r_addr   = addr_cnt;
  assign o_tx_data  = shift_reg[NB_BYTE-1:0];
  assign o_tx_valid = (state == SEND);
  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);

  // Next-state and datapath update; everything holds unless a rule moves it.
  always_comb begin
    state_next = state;
    addr_next  = addr_cnt;
    shift_next = shift_reg;
    byte_next  = byte_cnt;
    case (state)
      IDLE: begin
        if (i_start) begin
          addr_next  = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Snapshot the word so later register-file writes cannot touch
        // bytes still waiting to go out.
        shift_next = i_r_data;
        byte_next  = '0;
        state_next = SEND;
      end
      SEND: begin
        if (transfer) begin
          if (byte_cnt != LAST_BYTE) begin
            shift_next = shift_reg >> NB_BYTE;
            byte_next  = byte_cnt + 1'b1;
          end else if (addr_cnt == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_cnt + 1'b1;
            state_next = LOAD;
          end
        end
      end
      DONE: begin
        addr_next  = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else begin
      state     <= state_next;
      addr_cnt  <= addr_next;
      shift_reg <= shift_next;
      byte_cnt  <= byte_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_dump.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_dump
// Brief   : Self-checking bench for register_dump. A behavioural register
//           file feeds the DUT; expected byte streams are built directly from
//           the register contents at dump start.
// Revision: 1.0 - initial release
// ============================================================================
module tb_register_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign r_data = rf[r_addr];

  int checks   = 0;
  int failures = 0;

  // Results of the most recent run_dump call.
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int done_cnt;
  int done_cycle;
  int busy_cycles;
  int stall_bad;
  int timed_out;

  register_dump #(
    .NB_REGISTER(32),
    .NB_ADDR    (5),
    .NB_BYTE    (8)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_start   (start),
    .o_r_addr  (r_addr),
    .i_r_data  (r_data),
    .o_tx_data (tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stream: every register in ascending order, LSB first.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(rf[i][8*b +: 8]);
      end
    end
  endtask

  // Runs one dump; stimulus changes on falling edges, outputs observed there.
  // poke_byte  : pulse i_start when this many bytes have gone (and in DONE)
  // write_byte : overwrite reg[3] when this many bytes have gone
  // stop_byte  : return early (ready low) once this many bytes have gone
  task automatic run_dump(input int pct, input int poke_byte,
                          input int write_byte, input int stop_byte);
    int   cyc;
    logic prev_valid;
    logic prev_xfer;
    logic [7:0] prev_data;
    bit   poked;
    bit   written;
    bit   seen_done;
    got_q.delete();
    done_cnt = 0; done_cycle = -1; busy_cycles = 0; stall_bad = 0; timed_out = 0;
    prev_valid = 1'b0; prev_xfer = 1'b0; prev_data = '0;
    poked = 0; written = 0; seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (cyc > 3000) begin
        timed_out = 1;
        tx_ready = 1'b0;
        return;
      end
      if (done) begin
        done_cnt++;
        seen_done = 1;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (busy) busy_cycles++;
      if (prev_valid && !prev_xfer && (!tx_valid || tx_data !== prev_data)) stall_bad++;
      if (stop_byte >= 0 && got_q.size() == stop_byte) begin
        tx_ready = 1'b0;
        return;
      end
      if (seen_done && !busy) begin
        start = 1'b0;
        return;
      end
      start = 1'b0;
      if (!poked && poke_byte >= 0 && got_q.size() == poke_byte) begin
        start = 1'b1;
        poked = 1;
      end
      if (done && poke_byte >= 0) start = 1'b1;
      if (!written && write_byte >= 0 && got_q.size() == write_byte) begin
        rf[3] = 32'h11223344;
        written = 1;
      end
      tx_ready = ($urandom_range(99) < pct);
      prev_valid = tx_valid;
      prev_data  = tx_data;
      prev_xfer  = tx_valid && tx_ready;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic int count_mismatch();
    int n = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= got_q.size()) n++;
      else if (got_q[k] !== exp_q[k]) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (r_addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", r_addr); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", tx_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incrementing();
    int nbad;
    for (int i = 0; i < 32; i++) rf[i] = i;
    build_expected();
    run_dump(100, -1, -1, -1);
    nbad = count_mismatch();
    checks++; if (timed_out != 0) begin failures++; $display("FAIL inc_timeout: got %0d want 0", timed_out); end
    checks++; if (got_q.size() != 128) begin failures++; $display("FAIL inc_count: got %0d want 128", got_q.size()); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL inc_bytes: %0d bad bytes want 0", nbad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL inc_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cycle != 161) begin failures++; $display("FAIL inc_done_cycle: got %0d want 161", done_cycle); end
    checks++; if (busy_cycles != 161) begin failures++; $display("FAIL inc_busy_cycles: got %0d want 161", busy_cycles); end
    checks++; if (r_addr !== 5'd0) begin failures++; $display("FAIL inc_addr_idle: got %0d want 0", r_addr); end
  endtask

  task automatic test_deadbeef();
    logic [7:0] want [4];
    int nbad;
    want[0] = 8'hEF; want[1] = 8'hBE; want[2] = 8'hAD; want[3] = 8'hDE;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[5] = 32'hDEADBEEF;
    build_expected();
    run_dump(100, -1, -1, -1);
    nbad = count_mismatch();
    checks++; if (nbad != 0) begin failures++; $display("FAIL dead_bytes: %0d bad bytes want 0", nbad); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_q.size() <= 20 + k || got_q[20 + k] !== want[k]) begin
        failures++;
        $display("FAIL dead_byte%0d: got %h want %h", 20 + k,
                 (got_q.size() > 20 + k) ? got_q[20 + k] : 8'hxx, want[k]);
      end
    end
  endtask

  task automatic test_stall();
    int nbad;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected();
    run_dump(30, -1, -1, -1);
    nbad = count_mismatch();
    checks++; if (timed_out != 0) begin failures++; $display("FAIL stall_timeout: got %0d want 0", timed_out); end
    checks++; if (got_q.size() != 128) begin failures++; $display("FAIL stall_count: got %0d want 128", got_q.size()); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL stall_bytes: %0d bad bytes want 0", nbad); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_hold: %0d unstable cycles want 0", stall_bad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int nbad;
    int late_busy = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected();
    run_dump(100, 40, -1, -1);
    nbad = count_mismatch();
    repeat (8) begin
      @(negedge clk);
      if (busy) late_busy++;
    end
    checks++; if (got_q.size() != 128) begin failures++; $display("FAIL ign_count: got %0d want 128", got_q.size()); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL ign_bytes: %0d bad bytes want 0", nbad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (late_busy != 0) begin failures++; $display("FAIL ign_restart: busy %0d cycles want 0", late_busy); end
  endtask

  task automatic test_write_in_flight();
    for (int i = 0; i < 32; i++) rf[i] = i;
    build_expected();
    run_dump(100, -1, 13, -1);
    for (int k = 12; k < 16; k++) begin
      checks++;
      if (got_q.size() <= k || got_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL inflight_byte%0d: got %h want %h", k,
                 (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int nbad;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected();
    run_dump(100, -1, -1, 10);
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_pre_done: got %0d want 0", done_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (r_addr !== 5'd0) begin failures++; $display("FAIL abort_addr: got %0d want 0", r_addr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    run_dump(100, -1, -1, -1);
    nbad = count_mismatch();
    checks++; if (got_q.size() != 128) begin failures++; $display("FAIL abort_count: got %0d want 128", got_q.size()); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL abort_bytes: %0d bad bytes want 0", nbad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL abort_done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_incrementing();
    test_deadbeef();
    test_stall();
    test_start_ignored();
    test_write_in_flight();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
